// File: rtl/dm_tx_encoder.sv
// dm_tx_encoder: differential Manchester line transmitter.
// Takes bytes over a valid/ready handshake and sends them MSB first. The line
// toggles at every bit boundary and additionally at mid-bit for a 0 bit.
// Optional feature macro: DM_PARITY_EN appends one even-parity bit per byte.
module dm_tx_encoder #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       dm_out,
    output logic       busy
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef DM_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [3:0]       BIT_LAST = 4'(NBITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             half_q, half_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             dm_q, dm_d;
    logic             busy_q, busy_d;
    logic             shift_in;
    logic             div_wrap;
    logic             last_cycle;
    logic             accept;

`ifdef DM_PARITY_EN
    logic             par_q, par_d;

    // The parity bit is fed into the shift register from below, so after
    // eight shifts it sits in bit 7 and goes out with the same coding path.
    assign shift_in = par_q;
`else
    assign shift_in = 1'b0;
`endif

    assign div_wrap   = (div_cnt_q == DIV_LAST);
    assign last_cycle = (state_q == SEND) && half_q && div_wrap && (bit_cnt_q == BIT_LAST);
    assign ready_o    = tx_en && ((state_q == IDLE) || last_cycle);
    assign accept     = valid_i && ready_o;
    assign dm_out     = dm_q;
    assign busy       = busy_q;

    // Next-state logic: accept/reload, half-bit timing, bit shifting and line toggles
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        half_d    = half_q;
        div_cnt_d = div_cnt_q;
        dm_d      = dm_q;
        busy_d    = busy_q;
`ifdef DM_PARITY_EN
        par_d     = par_q;
`endif
        if (accept) begin
            // New byte: start-of-bit transition happens immediately.
            state_d   = SEND;
            shreg_d   = data_i;
            bit_cnt_d = '0;
            half_d    = 1'b0;
            div_cnt_d = '0;
            dm_d      = ~dm_q;
            busy_d    = 1'b1;
`ifdef DM_PARITY_EN
            par_d     = ^data_i;
`endif
        end else if (state_q == SEND) begin
            if (div_wrap) begin
                div_cnt_d = '0;
                if (!half_q) begin
                    // Mid-bit: a 0 bit gets the extra transition.
                    half_d = 1'b1;
                    if (!shreg_q[7]) begin
                        dm_d = ~dm_q;
                    end
                end else if (bit_cnt_q != BIT_LAST) begin
                    // Bit boundary: advance to the next bit and toggle.
                    half_d    = 1'b0;
                    shreg_d   = {shreg_q[6:0], shift_in};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    dm_d      = ~dm_q;
                end else begin
                    // End of byte with nobody waiting: line holds its level.
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    half_d    = 1'b0;
                    bit_cnt_d = '0;
                end
            end else begin
                div_cnt_d = div_cnt_q + CNT_W'(1);
            end
        end
    end

    // State and datapath registers; reset discards any byte in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            half_q    <= 1'b0;
            div_cnt_q <= '0;
            dm_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            half_q    <= half_d;
            div_cnt_q <= div_cnt_d;
            dm_q      <= dm_d;
            busy_q    <= busy_d;
        end
    end

`ifdef DM_PARITY_EN
    // Parity of the accepted byte, held for the ninth bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule
